// File: rtl/block_deserialiser.sv
// Byte-to-block deserialiser: packs up to 64 serial bytes into a 4x4 array of
// 32-bit words and presents it to a consumer via a valid/ready handshake.
// Optional feature macro: DESER_OVERRUN_EN adds a sticky overrun output.

package block_deserialiser_pkg;
  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

module block_deserialiser
  import block_deserialiser_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output word_t [3:0][3:0]     out_block,
  output logic [6:0]           out_count,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef DESER_OVERRUN_EN
  ,
  output logic                 overrun
`endif
);

  localparam int unsigned CNT_W     = 7;
  localparam int unsigned LAST_BYTE = 63;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  word_t [3:0][3:0]   block_q, block_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [3:0]         widx;
  logic [1:0]         lane;

  // Byte k lands in word k/4; words fill from [3][3] downwards, MSB lane first.
  assign widx = cnt_q[5:2];
  assign lane = cnt_q[1:0];

  // Next-state: fill bytes in FILL, hold then drain the block in FULL.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    block_d     = block_q;
    count_d     = count_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          block_d[~widx[3:2]][~widx[1:0]][{~lane, 3'b000} +: 8] = in_byte;
          cnt_d = cnt_q + CNT_W'(1);
          if (in_last || (cnt_q == CNT_W'(LAST_BYTE))) begin
            state_d = FULL;
            count_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = FILL;
          cnt_d   = '0;
          block_d = '0;
          count_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
    in_ready_d  = (state_d == FILL);
    out_valid_d = (state_d == FULL);
  end

  // State and registered outputs; reset wins over any same-cycle event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      block_q     <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      block_q     <= block_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_block = block_q;
  assign out_count = count_q;

`ifdef DESER_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky flag: producer offered a byte while the block was full.
  always_comb begin
    overrun_d = overrun_q | (in_valid & ~in_ready_q);
  end

  // Overrun register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule
